neuron_mac: RTL and testbench

Single-neuron multiply-accumulate stage: accepts a stream of NUM_INPUTS signed fixed-point activations, multiplies each by a locally stored weight, accumulates, adds a bias, then rescales and saturates to DATA_WIDTH. Sits directly upstream of the ReLU/MLP output path. Its saturated pre-activation result is the value the ReLU consumes. One instance per neuron; weights and bias are loaded by the MLP controller before inference.

---
 rtl/mlp_pkg.sv | 36 +++
 rtl/neuron_weight_mem.sv | 34 +++
 rtl/neuron_mac.sv | 157 +++++++++++++++
 tb/tb_neuron_mac.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared MLP types, default widths and the output rescale/saturate helper.
// Used by neuron_mac and neuron_weight_mem.
package mlp_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FRAC_BITS  = 4;
    localparam int DEF_ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Floor-shift by frac, then clamp to a dw-bit signed range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 dw
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sh > hi) begin
            sat_shift = hi;
        end else if (sh < lo) begin
            sat_shift = lo;
        end else begin
            sat_shift = sh;
        end
    endfunction

endpackage

// File: rtl/neuron_weight_mem.sv
// Per-neuron weight register file.
// Synchronous write port, combinational read at the MAC index.
module neuron_weight_mem
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS = 16,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_INPUTS];

    // Weight storage; reset clears all entries and wins over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(wr_addr) < NUM_INPUTS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: weighted sum of NUM_INPUTS activations plus bias,
// rescaled and saturated. Optional macro NEURON_MAC_RELU_EN clamps to >= 0.
module neuron_mac
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int NUM_INPUTS = 16,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_we,
    input  logic [IDX_W-1:0]      w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]            idx;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]       bias;
    logic [DATA_WIDTH-1:0]       w_rd;

    logic [PW-1:0]               a_ext;
    logic [PW-1:0]               w_ext;
    logic [PW-1:0]               prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [63:0]          sum_64;
    logic signed [63:0]          sat_64;
    logic [DATA_WIDTH-1:0]       res;

    logic xfer;
    logic last;
    logic hs;

    neuron_weight_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS)
    ) u_wmem (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .wr_addr (w_addr),
        .wr_data (w_data),
        .rd_addr (idx),
        .rd_data (w_rd)
    );

    assign xfer = in_valid & in_ready;
    assign last = (idx == LAST);
    assign hs   = out_valid & out_ready;

    // Full-width signed product; the low 2*DATA_WIDTH bits are exact.
    assign a_ext    = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    assign w_ext    = {{DATA_WIDTH{w_rd[DATA_WIDTH-1]}}, w_rd};
    assign prod     = a_ext * w_ext;
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign acc_base = (idx == '0) ? '0 : acc;

    // Bias is aligned to the product's 2*FRAC_BITS scale before the add.
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    assign sum      = acc + (bias_ext <<< FRAC_BITS);
    assign sum_64   = {{(64-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
    assign sat_64   = sat_shift(sum_64, FRAC_BITS, DATA_WIDTH);

`ifdef NEURON_MAC_RELU_EN
    assign res = sat_64[DATA_WIDTH-1] ? '0 : sat_64[DATA_WIDTH-1:0];
`else
    assign res = sat_64[DATA_WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    // Bias register; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias <= '0;
        end else if (b_we) begin
            bias <= b_data;
        end
    end

    // Accumulator, index, result register and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            acc      <= '0;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            if (xfer) begin
                acc  <= acc_base + prod_ext;
                idx  <= last ? '0 : idx + 1'b1;
                busy <= 1'b1;
            end
            if (state == FINISH) begin
                out_data <= res;
            end
            if (hs) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed inferences against an arithmetic model.
// Honours NEURON_MAC_RELU_EN when the build defines it.
module tb_neuron_mac;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_we = 1'b0;
    logic [3:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       b_we = 1'b0;
    logic [7:0] b_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;

    always #5 clk = ~clk;

    neuron_mac dut (
        .clk       (clk),
        .rst       (rst),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_we      (b_we),
        .b_data    (b_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] wm [16];
    logic [7:0] bm;
    int exp_q [$];
    int last_hs = 0;
    int hs_count = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Real-valued rule: floor(sum / 2^4), clamp to int8, optional ReLU.
    function automatic int model(input longint s);
        longint q;
        if (s >= 0) q = s / 16;
        else q = -((-s + 15) / 16);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef NEURON_MAC_RELU_EN
        if (q < 0) q = 0;
`endif
        return int'(q);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("out_data", int'($signed(out_data)), exp_q[0]);
                if (out_ready) begin
                    last_hs = int'($signed(out_data));
                    hs_count++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic load_all(input logic [7:0] w);
        for (int i = 0; i < 16; i++) begin
            w_we = 1'b1;
            w_addr = 4'(i);
            w_data = w;
            @(posedge clk); #1;
            wm[i] = w;
        end
        w_we = 1'b0;
    endtask

    task automatic load_one(input int i, input logic [7:0] w);
        w_we = 1'b1;
        w_addr = 4'(i);
        w_data = w;
        @(posedge clk); #1;
        wm[i] = w;
        w_we = 1'b0;
    endtask

    task automatic load_bias(input logic [7:0] b);
        b_we = 1'b1;
        b_data = b;
        @(posedge clk); #1;
        bm = b;
        b_we = 1'b0;
    endtask

    task automatic run_inf(
        input  logic [7:0] a [16],
        input  bit         gaps,
        input  bit         collide,
        output int         expv
    );
        longint s;
        int n;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin @(posedge clk); #1; end
            end
            n = 0;
            while (!in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) check("in_ready_timeout", 0, 1);
            in_valid = 1'b1;
            in_data = a[i];
            if (collide) begin
                w_we = 1'b1;
                w_addr = 4'(i);
                w_data = 8'($urandom_range(0, 255));
            end
            s += longint'($signed(a[i])) * longint'($signed(wm[i]));
            @(posedge clk); #1;
            if (i == 0) check("busy_set", int'(busy), 1);
            if (collide) begin
                wm[i] = w_data;
                w_we = 1'b0;
            end
            in_valid = 1'b0;
        end
        s += longint'($signed(bm)) * 16;
        expv = model(s);
        exp_q.push_back(expv);
        check("finish_in_ready", int'(in_ready), 0);
        check("finish_out_valid", int'(out_valid), 0);
        if (collide) begin
            b_we = 1'b1;
            b_data = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        if (collide) begin
            bm = b_data;
            b_we = 1'b0;
        end
        check("latency_out_valid", int'(out_valid), 1);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("handshake_timeout", 0, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a [16];
        int e;
        int r0;
        int want;
        for (int i = 0; i < 16; i++) wm[i] = '0;
        bm = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;
        out_ready = 1'b1;

        // 1.0 * 1.0 * 16 saturates high
        load_all(8'h10);
        load_bias(8'h00);
        for (int i = 0; i < 16; i++) a[i] = 8'h10;
        run_inf(a, 1'b0, 1'b0, e);
        check("t1_model", e, 127);
        wait_hs(1);
        check("t1_out", last_hs, 127);

        // 0.5 * 0.125 * 16 - 1.0 = 0
        load_all(8'h08);
        load_bias(8'hF0);
        for (int i = 0; i < 16; i++) a[i] = 8'h02;
        run_inf(a, 1'b0, 1'b0, e);
        check("t2_model", e, 0);
        wait_hs(2);
        check("t2_out", last_hs, 0);

        // -1.0 * 1.0 * 16 saturates low
        load_all(8'hF0);
        load_bias(8'h00);
        for (int i = 0; i < 16; i++) a[i] = 8'h10;
        run_inf(a, 1'b0, 1'b0, e);
`ifdef NEURON_MAC_RELU_EN
        want = 0;
`else
        want = -128;
`endif
        check("t3_model", e, want);
        wait_hs(3);
        check("t3_out", last_hs, want);

        // back-pressure: 1.0 * 0.25 * 16 = 4.0 held for 5 cycles
        load_all(8'h10);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) a[i] = 8'h04;
        run_inf(a, 1'b0, 1'b0, e);
        check("t4_model", e, 64);
        in_valid = 1'b1;
        in_data = 8'h7F;
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_busy", int'(busy), 1);
            check("stall_out_data", int'(out_data), 64);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_hs", last_hs, 64);
        check("post_hs_out_valid", int'(out_valid), 0);
        check("post_hs_busy", int'(busy), 0);
        check("post_hs_in_ready", int'(in_ready), 1);

        // random weights, gaps, same-cycle weight and FINISH bias writes
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) load_one(i, 8'($urandom_range(0, 255)));
            load_bias(8'($urandom_range(0, 255)));
            for (int i = 0; i < 16; i++) a[i] = 8'($urandom_range(0, 255));
            run_inf(a, 1'b1, 1'b1, e);
            wait_hs(5 + r);
        end

        // reference run, then the same run after a mid-inference reset
        load_all(8'h10);
        load_bias(8'h00);
        for (int i = 0; i < 16; i++) a[i] = 8'(i - 8);
        run_inf(a, 1'b0, 1'b0, e);
`ifdef NEURON_MAC_RELU_EN
        want = 0;
`else
        want = -8;
`endif
        check("t6_model", e, want);
        wait_hs(8);
        r0 = last_hs;
        check("t6_ref_out", r0, want);

        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = a[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        w_we = 1'b1;
        w_addr = 4'd0;
        w_data = 8'h7F;
        @(posedge clk); #1;
        rst = 1'b0;
        w_we = 1'b0;
        for (int i = 0; i < 16; i++) wm[i] = '0;
        bm = '0;
        check_reset_outs("midrst");

        load_all(8'h10);
        run_inf(a, 1'b0, 1'b0, e);
        wait_hs(9);
        check("t6_after_reset", last_hs, r0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
